imem_ctrl: RTL and testbench
============================

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte-address width of both requester ports.
REQ-002 Parameter DATA_WIDTH, default 32: instruction word width.
REQ-003 Parameter WORD_BITS, default 18: memory word-address width (depth 1<<18).
REQ-004 Parameter STARVE_LIMIT, default 8: number of consecutive denied loader cycles in RUN before the loader is forced a grant.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 boot_done  in  1  loader finished; level, sampled each cycle.
REQ-008 f_req / f_addr  in  1 / ADDR_WIDTH  fetch read request and byte PC.
REQ-009 f_gnt / f_valid / f_inst  out  1 / 1 / DATA_WIDTH  fetch grant, read-data valid, instruction.
REQ-010 f_misalign  out  1  fetch address misaligned (macro-dependent).
REQ-011 l_req / l_we / l_addr / l_wdata  in  1 / 1 / ADDR_WIDTH / DATA_WIDTH  loader request, write enable, byte address, write data.
REQ-012 l_gnt / l_valid / l_rdata  out  1 / 1 / DATA_WIDTH  loader grant, read-data valid, read data.
REQ-013 m_en / m_we / m_addr / m_wdata  out  1 / 1 / WORD_BITS / DATA_WIDTH  memory port; m_addr = granted address bits [WORD_BITS+1:2].
REQ-014 m_rdata  in  DATA_WIDTH  memory read data, valid one cycle after m_en with m_we=0.
REQ-015 state  out  2  current FSM state, for debug.

Function
REQ-016 FSM states: BOOT (loader-only), RUN (shared); BOOT->RUN on the first clock edge with boot_done=1; RUN->BOOT only on rst.
REQ-017 f_gnt and l_gnt are combinational in the request cycle, never both high; the granted requester drives m_en=1 in that same cycle.
REQ-018 In BOOT: l_gnt=l_req; f_gnt=0.
REQ-019 In RUN: fetch has priority, unless starve_cnt==STARVE_LIMIT and l_req=1, in which case the loader is granted.
REQ-020 starve_cnt: increments (saturating at STARVE_LIMIT) on each RUN cycle with l_req=1 and l_gnt=0; clears on l_gnt or on l_req=0.
REQ-021 Read latency: a read granted in cycle N raises the matching *_valid for exactly cycle N+1, with data = m_rdata; the port is fully pipelined (back-to-back grants yield back-to-back valids).
REQ-022 Loader writes (l_we=1): m_we=1 in the grant cycle; no l_valid is produced.
REQ-023 Address bits above WORD_BITS+1 are ignored (addresses wrap modulo the memory size).
REQ-024 f_inst / l_rdata hold their last valid value while *_valid=0.
REQ-025 boot_done rising in the same cycle as a loader grant: the loader access completes; fetch is eligible from the next cycle.

Reset
REQ-026 On rst: state=BOOT, starve_cnt=0, f_valid=0, l_valid=0, f_misalign=0, f_inst=0, l_rdata=0; m_en=0 and all grants are 0 while rst=1.
REQ-027 A read in flight when rst asserts produces no valid.

Configuration
REQ-028 Macro IMEM_CTRL_MISALIGN_TRAP_EN defined: a fetch request with f_addr[1:0]!=0 in RUN is granted but issues no memory access (m_en=0); f_misalign=1 and f_valid=0 in cycle N+1.
REQ-029 Macro IMEM_CTRL_MISALIGN_TRAP_EN undefined: f_addr[1:0] is ignored, the word is read normally, and f_misalign is tied to 0.

Structure
REQ-030 Shared package imem_pkg holds the state enum (BOOT=2'd0, RUN=2'd1) and default width constants; RTL uses package names only.
REQ-031 The starvation counter is a sub-module, imem_starve_cnt (inputs: inc, clr; output: sat).

Verification
REQ-032 rst, then l_req/l_we=1 with l_addr=0x0, 0x4, l_wdata=0x00500093, 0x00100113; f_req=1 throughout -> two m_we pulses at words 0 and 1; f_gnt=0 throughout.
REQ-033 boot_done=1, then f_addr=0x0 and 0x4 back-to-back -> f_valid in cycles N+1 and N+2 with f_inst=0x00500093, 0x00100113.
REQ-034 RUN, f_req=1 continuously with l_req=1 (read 0x4) -> l_gnt on the 9th cycle, l_valid the next cycle with l_rdata=0x00100113, starve_cnt=0.
REQ-035 With macro defined, f_addr=0x6 -> m_en=0, f_misalign=1, f_valid=0 next cycle; without macro -> f_inst=word 1.
REQ-036 f_addr=0x00100004 -> m_addr=1 (wrap); rst asserted in the cycle after a grant -> no f_valid, state=BOOT.

Source files
------------

// File: rtl/imem_pkg.sv
// ============================================================================
// Module : imem_pkg
// Brief  : Shared state encoding and default widths for the imem controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1
  } state_t;

  localparam int c_addr_width   = 32;
  localparam int c_data_width   = 32;
  localparam int c_word_bits    = 18;
  localparam int c_starve_limit = 8;

endpackage

`default_nettype wire

// File: rtl/imem_starve_cnt.sv
// ============================================================================
// Module : imem_starve_cnt
// Brief  : Saturating count of consecutive denied loader cycles.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_starve_cnt #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int c_w = $clog2(LIMIT + 1);
  localparam logic [c_w-1:0] c_limit = c_w'(LIMIT);

  logic [c_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sat = (r_cnt == c_limit);

endmodule

`default_nettype wire

// File: rtl/imem_ctrl.sv
// ============================================================================
// Module : imem_ctrl
// Brief  : Instruction-memory arbiter between fetch and loader, BOOT/RUN FSM.
//          Optional macro IMEM_CTRL_MISALIGN_TRAP_EN traps misaligned fetches.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH   = c_addr_width,
  parameter int DATA_WIDTH   = c_data_width,
  parameter int WORD_BITS    = c_word_bits,
  parameter int STARVE_LIMIT = c_starve_limit
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_done,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_valid,
  output logic [DATA_WIDTH-1:0] f_inst,
  output logic                  f_misalign,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_valid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [WORD_BITS-1:0]  m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            state
);

  state_t                r_state;
  logic                  r_f_pend;
  logic                  r_l_pend;
  logic                  r_mis;
  logic [DATA_WIDTH-1:0] r_f_hold;
  logic [DATA_WIDTH-1:0] r_l_hold;

  logic w_run;
  logic w_sat;
  logic w_force;
  logic w_f_gnt;
  logic w_l_gnt;
  logic w_f_mis;

  assign w_run   = (r_state == RUN);
  assign w_force = w_run & w_sat & l_req;

  // Fetch wins in RUN unless the loader has waited long enough.
  assign w_f_gnt = ~rst & w_run & f_req & ~w_force;
  assign w_l_gnt = ~rst & l_req & (~w_run | w_force | ~f_req);

`ifdef IMEM_CTRL_MISALIGN_TRAP_EN
  assign w_f_mis = w_f_gnt & (f_addr[1:0] != 2'b00);
`else
  assign w_f_mis = 1'b0;
`endif

  assign f_gnt   = w_f_gnt;
  assign l_gnt   = w_l_gnt;
  assign m_en    = w_l_gnt | (w_f_gnt & ~w_f_mis);
  assign m_we    = w_l_gnt & l_we;
  assign m_addr  = w_l_gnt ? l_addr[WORD_BITS+1:2] : f_addr[WORD_BITS+1:2];
  assign m_wdata = l_wdata;

  imem_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (w_run & l_req & ~w_l_gnt),
    .clr (w_l_gnt | ~l_req),
    .sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= BOOT;
      r_f_pend <= 1'b0;
      r_l_pend <= 1'b0;
      r_mis    <= 1'b0;
      r_f_hold <= '0;
      r_l_hold <= '0;
    end else begin
      if ((r_state == BOOT) && boot_done) begin
        r_state <= RUN;
      end
      r_f_pend <= w_f_gnt & ~w_f_mis;
      r_l_pend <= w_l_gnt & ~l_we;
      r_mis    <= w_f_mis;
      if (r_f_pend) r_f_hold <= m_rdata;
      if (r_l_pend) r_l_hold <= m_rdata;
    end
  end

  // Gating with rst kills a read that was in flight when reset arrived.
  assign f_valid    = r_f_pend & ~rst;
  assign l_valid    = r_l_pend & ~rst;
  assign f_inst     = f_valid ? m_rdata : r_f_hold;
  assign l_rdata    = l_valid ? m_rdata : r_l_hold;
  assign f_misalign = r_mis;
  assign state      = r_state;

  generate
    if (ADDR_WIDTH > WORD_BITS + 2) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^{f_addr[ADDR_WIDTH-1:WORD_BITS+2],
                             l_addr[ADDR_WIDTH-1:WORD_BITS+2]};
    end
  endgenerate

  logic w_unused_lo;
  assign w_unused_lo = ^{f_addr[1:0], l_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_imem_ctrl.sv
// ============================================================================
// Module : tb_imem_ctrl
// Brief  : Directed self-checking bench for imem_ctrl with a small RAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imem_ctrl;

  localparam logic [31:0] c_w0 = 32'h00500093;
  localparam logic [31:0] c_w1 = 32'h00100113;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_done;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_valid;
  logic [31:0] f_inst;
  logic        f_misalign;
  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_valid;
  logic [31:0] l_rdata;
  logic        m_en;
  logic        m_we;
  logic [17:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  imem_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .boot_done  (boot_done),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_gnt      (f_gnt),
    .f_valid    (f_valid),
    .f_inst     (f_inst),
    .f_misalign (f_misalign),
    .l_req      (l_req),
    .l_we       (l_we),
    .l_addr     (l_addr),
    .l_wdata    (l_wdata),
    .l_gnt      (l_gnt),
    .l_valid    (l_valid),
    .l_rdata    (l_rdata),
    .m_en       (m_en),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .state      (state)
  );

  // Synchronous single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[7:0]] <= m_wdata;
      else      m_rdata <= mem[m_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    m_rdata   = '0;
    rst       = 1'b1;
    boot_done = 1'b0;
    f_req     = 1'b1;
    f_addr    = '0;
    l_req     = 1'b1;
    l_we      = 1'b0;
    l_addr    = '0;
    l_wdata   = '0;
    tick();
    tick();
    #1;
    check("rst_l_gnt",      l_gnt,      0);
    check("rst_f_gnt",      f_gnt,      0);
    check("rst_m_en",       m_en,       0);
    check("rst_state",      state,      0);
    check("rst_f_valid",    f_valid,    0);
    check("rst_l_valid",    l_valid,    0);
    check("rst_f_inst",     f_inst,     0);
    check("rst_l_rdata",    l_rdata,    0);
    check("rst_f_misalign", f_misalign, 0);

    // BOOT: loader writes words 0 and 1 while fetch keeps requesting
    rst = 1'b0; l_we = 1'b1; l_addr = 32'h0; l_wdata = c_w0;
    #1;
    check("boot_wr0_l_gnt",  l_gnt,  1);
    check("boot_wr0_f_gnt",  f_gnt,  0);
    check("boot_wr0_m_en",   m_en,   1);
    check("boot_wr0_m_we",   m_we,   1);
    check("boot_wr0_m_addr", m_addr, 0);
    tick();
    l_addr = 32'h4; l_wdata = c_w1;
    #1;
    check("boot_wr1_f_gnt",  f_gnt,  0);
    check("boot_wr1_m_we",   m_we,   1);
    check("boot_wr1_m_addr", m_addr, 1);
    tick();
    l_we = 1'b0; l_addr = 32'h0;
    #1;
    check("boot_wr_no_valid", l_valid, 0);
    check("boot_rd0_l_gnt",   l_gnt,   1);
    check("boot_rd0_m_we",    m_we,    0);
    tick();
    // loader read granted in the same cycle boot_done rises
    l_addr = 32'h4; boot_done = 1'b1;
    #1;
    check("boot_rd0_l_valid", l_valid, 1);
    check("boot_rd0_l_rdata", l_rdata, c_w0);
    check("boot_last_state",  state,   0);
    check("boot_rd1_l_gnt",   l_gnt,   1);
    check("boot_rd1_f_gnt",   f_gnt,   0);
    tick();
    // RUN: back-to-back fetches
    l_req = 1'b0; f_addr = 32'h0;
    #1;
    check("run_state",       state,   1);
    check("boot_rd1_l_valid", l_valid, 1);
    check("boot_rd1_l_rdata", l_rdata, c_w1);
    check("fetch0_f_gnt",    f_gnt,   1);
    check("fetch0_m_addr",   m_addr,  0);
    tick();
    f_addr = 32'h4;
    #1;
    check("fetch0_f_valid",  f_valid, 1);
    check("fetch0_f_inst",   f_inst,  c_w0);
    check("l_rdata_hold",    l_rdata, c_w1);
    check("fetch1_f_gnt",    f_gnt,   1);
    tick();
    f_req = 1'b0;
    #1;
    check("fetch1_f_valid",  f_valid, 1);
    check("fetch1_f_inst",   f_inst,  c_w1);
    check("idle_m_en",       m_en,    0);
    tick();
    #1;
    check("idle_f_valid",    f_valid, 0);
    check("f_inst_hold",     f_inst,  c_w1);

    // Starvation: loader forced through on the 9th denied cycle
    f_req = 1'b1; f_addr = 32'h0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4;
    for (int k = 1; k <= 9; k++) begin
      #1;
      check($sformatf("starve_l_gnt_%0d", k), l_gnt, (k == 9) ? 1 : 0);
      check($sformatf("starve_f_gnt_%0d", k), f_gnt, (k == 9) ? 0 : 1);
      tick();
    end
    l_req = 1'b0;
    #1;
    check("starve_l_valid", l_valid, 1);
    check("starve_l_rdata", l_rdata, c_w1);
    check("starve_f_valid", f_valid, 0);
    check("starve_cnt_clr", u_dut.u_starve.r_cnt, 0);
    check("starve_f_gnt",   f_gnt,   1);
    tick();

    // Misaligned fetch
    f_addr = 32'h6;
    #1;
    check("mis_f_gnt", f_gnt, 1);
`ifdef IMEM_CTRL_MISALIGN_TRAP_EN
    check("mis_m_en", m_en, 0);
`else
    check("mis_m_en",   m_en,   1);
    check("mis_m_addr", m_addr, 1);
`endif
    tick();
    f_req = 1'b0;
    #1;
`ifdef IMEM_CTRL_MISALIGN_TRAP_EN
    check("mis_f_misalign", f_misalign, 1);
    check("mis_f_valid",    f_valid,    0);
`else
    check("mis_f_misalign", f_misalign, 0);
    check("mis_f_valid",    f_valid,    1);
    check("mis_f_inst",     f_inst,     c_w1);
`endif
    tick();

    // Address wrap modulo memory size
    f_req = 1'b1; f_addr = 32'h00100004;
    #1;
    check("wrap_f_gnt",  f_gnt,  1);
    check("wrap_m_en",   m_en,   1);
    check("wrap_m_addr", m_addr, 1);
    tick();
    f_req = 1'b0;
    #1;
    check("wrap_f_valid",    f_valid,    1);
    check("wrap_f_inst",     f_inst,     c_w1);
    check("wrap_f_misalign", f_misalign, 0);

    // Reset while a fetch read is in flight
    f_req = 1'b1; f_addr = 32'h0;
    #1;
    check("flight_f_gnt", f_gnt, 1);
    tick();
    rst = 1'b1; f_req = 1'b0;
    #1;
    check("flight_f_valid", f_valid, 0);
    tick();
    #1;
    check("flight_state",   state,   0);
    check("flight_f_valid2", f_valid, 0);
    check("flight_f_inst",  f_inst,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
